// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch unit
// Purpose: FSM state enum, NOP opcode and program-memory word-address width
//          used by instr_fetch and ifetch_linebuf.
// Ports:   none (package).
package instr_fetch_pkg;

  localparam int WADDR_W = 14;
  localparam logic [7:0] NOP_OP = 8'h00;

  typedef logic [WADDR_W-1:0] waddr_t;

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_WAIT   = 2'd1,
    ST_VALID  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_linebuf.sv
// rtl/ifetch_linebuf.sv - two-entry direct-mapped instruction word buffer
// Purpose: holds up to two program-memory words, indexed by word address bit 0,
//          tagged with the full word address. Two combinational lookup ports,
//          one fill port, one bulk invalidate.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears valid bits)
//   inv                   clear all valid bits
//   fill_en/addr/data     write one word into slot fill_addr[0]
//   addr_a/hit_a/data_a   lookup port A
//   addr_b/hit_b/data_b   lookup port B
module ifetch_linebuf
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inv,
  input  logic        fill_en,
  input  waddr_t      fill_addr,
  input  logic [31:0] fill_data,
  input  waddr_t      addr_a,
  output logic        hit_a,
  output logic [31:0] data_a,
  input  waddr_t      addr_b,
  output logic        hit_b,
  output logic [31:0] data_b
);

  logic [1:0]  valid;
  waddr_t      tag  [2];
  logic [31:0] data [2];

  // A fill in the same cycle as an invalidate survives: the returning word is
  // always recorded under the tag it was issued with.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 2'b00;
    end else begin
      if (inv) begin
        valid <= 2'b00;
      end
      if (fill_en) begin
        valid[fill_addr[0]] <= 1'b1;
        tag[fill_addr[0]]   <= fill_addr;
        data[fill_addr[0]]  <= fill_data;
      end
    end
  end

  assign hit_a  = valid[addr_a[0]] && (tag[addr_a[0]] == addr_a);
  assign data_a = data[addr_a[0]];
  assign hit_b  = valid[addr_b[0]] && (tag[addr_b[0]] == addr_b);
  assign data_b = data[addr_b[0]];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with 2-word line buffer
// Purpose: presents opcode byte and two argument bytes at cpu byte address pc,
//          fetching one or two big-endian words through a 1-cycle instruction
//          port; passes data-segment words through a separate data port.
// Config:  IFETCH_LINEBUF_EN defined keeps buffered words across pc changes;
//          undefined, every pc change invalidates the buffer.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pc, dataindex               cpu byte address / data segment word index
//   imem_addr, imem_rd          instruction-port word address and read strobe
//   imem_rdata                  instruction-port read data (1 cycle after imem_rd)
//   dmem_addr, dmem_rdata       data-port word address and read data
//   op_code, arg1, arg2         bytes at pc, pc+1, pc+2 (NOP/0 when not valid)
//   dataparams                  data segment word
//   insn_valid                  op_code/arg1/arg2 belong to the current pc
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [WADDR_W-1:0] DATA_BASE = 14'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        pc,
  input  logic [15:0]        dataindex,
  output logic [WADDR_W-1:0] imem_addr,
  output logic               imem_rd,
  input  logic [31:0]        imem_rdata,
  output logic [WADDR_W-1:0] dmem_addr,
  input  logic [31:0]        dmem_rdata,
  output logic [7:0]         op_code,
  output logic [7:0]         arg1,
  output logic [7:0]         arg2,
  output logic [31:0]        dataparams,
  output logic               insn_valid
);

  fetch_state_t state, state_next;
  logic [15:0]  pc_q;
  waddr_t       req_addr;

  waddr_t       w0, w1, issue_addr;
  logic         need1, pc_change, inv, fill_en;
  logic         hit0, hit1, p0, p1, do_lookup, issue;
  logic [31:0]  d0, d1;
  logic [63:0]  line;

  assign w0        = pc[15:2];
  assign w1        = w0 + 14'd1;   // wraps 14'h3FFF -> 14'h0000
  assign need1     = pc[1];
  assign pc_change = (pc != pc_q);
  assign fill_en   = (state == ST_WAIT) && !rst;

`ifdef IFETCH_LINEBUF_EN
  assign inv = 1'b0;
`else
  assign inv = pc_change && !rst;
`endif

  ifetch_linebuf u_linebuf (
    .clk       (clk),
    .rst       (rst),
    .inv       (inv),
    .fill_en   (fill_en),
    .fill_addr (req_addr),
    .fill_data (imem_rdata),
    .addr_a    (w0),
    .hit_a     (hit0),
    .data_a    (d0),
    .addr_b    (w1),
    .hit_b     (hit1),
    .data_b    (d1)
  );

  // The word being written this cycle counts as present, so the second read of
  // a two-word fetch can issue back-to-back with the first fill.
  assign p0 = (hit0 && !inv) || (fill_en && (req_addr == w0));
  assign p1 = !need1 || (hit1 && !inv) || (fill_en && (req_addr == w1));

  always_comb begin
    state_next = state;
    do_lookup  = 1'b0;
    issue      = 1'b0;
    issue_addr = w0;
    case (state)
      ST_LOOKUP: do_lookup = 1'b1;
      ST_WAIT: begin
        if (pc_change) state_next = ST_LOOKUP;
        else           do_lookup  = 1'b1;
      end
      ST_VALID:  do_lookup = pc_change;
      default:   state_next = ST_LOOKUP;
    endcase
    if (do_lookup) begin
      if (p0 && p1) begin
        state_next = ST_VALID;
      end else begin
        issue      = 1'b1;
        issue_addr = p0 ? w1 : w0;
        state_next = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOOKUP;
      pc_q     <= 16'h0000;
      req_addr <= '0;
    end else begin
      state <= state_next;
      if (do_lookup) pc_q     <= pc;
      if (issue)     req_addr <= issue_addr;
    end
  end

  assign imem_rd    = issue && !rst;
  assign imem_addr  = issue_addr;
  assign insn_valid = (state == ST_VALID) && !pc_change && !rst;

  // Big-endian: byte offset 0 is bits 31:24 of w0; offsets 4..5 spill into w1.
  assign line    = {d0, d1} << {pc[1:0], 3'b000};
  assign op_code = insn_valid ? line[63:56] : NOP_OP;
  assign arg1    = insn_valid ? line[55:48] : 8'h00;
  assign arg2    = insn_valid ? line[47:40] : 8'h00;

  assign dmem_addr  = DATA_BASE + dataindex[WADDR_W-1:0];
  assign dataparams = dmem_rdata;

  logic unused_bits;
  assign unused_bits = ^{dataindex[15:14], line[39:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc, dataindex;
  logic [13:0] imem_addr, dmem_addr;
  logic        imem_rd, insn_valid;
  logic [31:0] imem_rdata, dmem_rdata, dataparams;
  logic [7:0]  op_code, arg1, arg2;

`ifdef IFETCH_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic [31:0] imem [0:16383];
  logic [31:0] dmem [0:16383];

  int total = 0;
  int bad   = 0;

  instr_fetch #(.DATA_BASE(14'h0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .dataindex  (dataindex),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .op_code    (op_code),
    .arg1       (arg1),
    .arg2       (arg2),
    .dataparams (dataparams),
    .insn_valid (insn_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd === 1'b1) imem_rdata <= imem[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pc(input logic [15:0] p, output int lat, output int nrd,
                        output logic [13:0] a0, output logic [13:0] a1);
    lat = -1; nrd = 0; a0 = '0; a1 = '0;
    pc = p;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (imem_rd === 1'b1) begin
        if (nrd == 0) a0 = imem_addr;
        else          a1 = imem_addr;
        nrd++;
      end
      if (insn_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic fetch(input string tag, input logic [15:0] p, input int e_lat, input int e_nrd,
                       input logic [13:0] e_a0, input logic [13:0] e_a1,
                       input logic [7:0] e_op, input logic [7:0] e_x1, input logic [7:0] e_x2);
    int lat, nrd;
    logic [13:0] a0, a1;
    run_pc(p, lat, nrd, a0, a1);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_nrd"}, nrd, e_nrd);
    chk({tag, "_a0"},  a0,  e_a0);
    chk({tag, "_a1"},  a1,  e_a1);
    chk({tag, "_op"},  op_code, e_op);
    chk({tag, "_arg1"}, arg1, e_x1);
    chk({tag, "_arg2"}, arg2, e_x2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    imem[14'h0000] = 32'h102A3C00;
    imem[14'h0001] = 32'hAABBB800;
    imem[14'h0002] = 32'h01020000;
    imem[14'h0010] = 32'h55667788;
    imem[14'h3FFF] = 32'h11223344;
    dmem[14'h0105] = 32'hDEADBEEF;
    dmem[14'h0000] = 32'hCAFEF00D;

    rst = 1'b1; pc = 16'h0000; dataindex = 16'h0000;
    repeat (2) tick();
    #1;
    chk("rst_valid", insn_valid, 1'b0);
    chk("rst_op", op_code, 8'h00);
    chk("rst_rd", imem_rd, 1'b0);
    rst = 1'b0;

    fetch("pc0", 16'h0000, 2, 1, 14'h0000, 14'h0000, 8'h10, 8'h2A, 8'h3C);
    tick();
    fetch("pc1", 16'h0001, LB ? 1 : 2, LB ? 0 : 1, 14'h0000, 14'h0000, 8'h2A, 8'h3C, 8'h00);
    tick();
    fetch("pc6", 16'h0006, 3, 2, 14'h0001, 14'h0002, 8'hB8, 8'h00, 8'h01);
    tick();
    fetch("pc7", 16'h0007, LB ? 1 : 3, LB ? 0 : 2, LB ? 14'h0000 : 14'h0001,
          LB ? 14'h0000 : 14'h0002, 8'h00, 8'h01, 8'h02);
    tick();
    fetch("pcffff", 16'hFFFF, 3, 2, 14'h3FFF, 14'h0000, 8'h44, 8'h10, 8'h2A);
    tick();
    fetch("pcfffe", 16'hFFFE, LB ? 1 : 3, LB ? 0 : 2, LB ? 14'h0000 : 14'h3FFF,
          14'h0000, 8'h33, 8'h44, 8'h10);

    // pc moves while the read for word 2 is in flight
    tick();
    pc = 16'h0008;
    #1;
    chk("wait_rd", imem_rd, 1'b1);
    chk("wait_addr", imem_addr, 14'h0002);
    tick();
    pc = 16'h0004;
    #1;
    chk("wait_op", op_code, 8'h00);
    chk("wait_valid", insn_valid, 1'b0);
    chk("wait_rd2", imem_rd, 1'b0);
    fetch("pc4", 16'h0004, 3, 1, 14'h0001, 14'h0000, 8'hAA, 8'hBB, 8'hB8);
    tick();
    fetch("pc8", 16'h0008, LB ? 1 : 2, LB ? 0 : 1, LB ? 14'h0000 : 14'h0002,
          14'h0000, 8'h01, 8'h02, 8'h00);

    // reset while a read is outstanding
    tick();
    pc = 16'h0040;
    #1;
    chk("rstw_rd", imem_rd, 1'b1);
    chk("rstw_addr", imem_addr, 14'h0010);
    tick();
    rst = 1'b1;
    #1;
    chk("rstw_rd_hold", imem_rd, 1'b0);
    chk("rstw_valid", insn_valid, 1'b0);
    tick();
    rst = 1'b0;
    fetch("post_rst", 16'h0008, 2, 1, 14'h0002, 14'h0000, 8'h01, 8'h02, 8'h00);

    // data port
    tick();
    dataindex = 16'h0005;
    #1;
    chk("dmem_addr", dmem_addr, 14'h0105);
    tick();
    chk("dataparams", dataparams, 32'hDEADBEEF);
    dataindex = 16'hFF00;
    #1;
    chk("dmem_wrap", dmem_addr, 14'h0000);
    tick();
    chk("dataparams_wrap", dataparams, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
